// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: FSM states, opcodes and framing bytes.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_EXEC,
        ST_RDWAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_LUT_WR  = 8'h01;
    localparam logic [7:0] CMD_LUT_RD  = 8'h02;
    localparam logic [7:0] CMD_CTRL_WR = 8'h03;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;
    localparam logic [7:0] RESP_NAK  = 8'hEE;

    // UART RX error code meaning "no error"
    localparam logic [1:0] NOERROR = 2'd0;

    function automatic logic is_valid_cmd(input logic [7:0] c);
        return (c == CMD_LUT_WR) || (c == CMD_LUT_RD) || (c == CMD_CTRL_WR);
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte idle timer: counts enabled clocks, expires on reaching TIMEOUTCYCLES-1.
// Latency: expire is combinational on the count; clear dominates enable.
// Backpressure: none, pure counter.
module uart_timeout_cnt #(
    parameter int TIMEOUTCYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUTCYCLES > 2) ? $clog2(TIMEOUTCYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUTCYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames SYNC/CMD/ADDR/DATA/CSUM packets from the RX FIFO, drives the LUT / ctrl reg, answers on TX.
// Latency: LUT strobe 1 clk after the CSUM pop; write/ctrl ACK 2 clks, read data 3 clks, NAK 1 clk.
// Backpressure: holds the response while txFull; RX is not popped until the response is pushed.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int          LUTADDRBIT    = 8,
    parameter int          LUTDATABIT    = 8,
    parameter int          TIMEOUTCYCLES = 1_000_000,
    parameter logic [7:0]  SYNCBYTE      = SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rxData,
    input  logic                  rxEmpty,
    output logic                  rxRead,
    input  logic [1:0]            rxError,
    output logic                  lutWe,
    output logic                  lutRe,
    output logic [LUTADDRBIT-1:0] lutAddr,
    output logic [LUTDATABIT-1:0] lutWdata,
    input  logic [LUTDATABIT-1:0] lutRdata,
    output logic [7:0]            txData,
    output logic                  txWrite,
    input  logic                  txFull,
    output logic                  gammaEnable,
    output logic [7:0]            errCount
);

    state_t     state, state_nxt;
    logic [7:0] cmd_q, addr_q, data_q;
    logic       byte_st, pkt_st, pop, abort, csum_ok, err_inc, tmo_expire;

    assign byte_st = state inside {ST_HUNT, ST_CMD, ST_ADDR, ST_DATA, ST_CSUM};
    assign pkt_st  = state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CSUM};
    assign pop     = byte_st && !rxEmpty && !rst;
    // A line error in the same clock as a pop wins; the popped byte is dropped.
    assign abort   = pkt_st && ((rxError != NOERROR) || tmo_expire);
    assign csum_ok = (rxData == (cmd_q ^ addr_q ^ data_q)) && is_valid_cmd(cmd_q);
    assign err_inc = abort || ((state == ST_CSUM) && pop && !csum_ok);

    uart_timeout_cnt #(
        .TIMEOUTCYCLES(TIMEOUTCYCLES)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clear (pop || !pkt_st),
        .enable(pkt_st && rxEmpty),
        .expire(tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT:   if (pop && (rxData == SYNCBYTE)) state_nxt = ST_CMD;
            ST_CMD:    if (abort) state_nxt = ST_HUNT; else if (pop) state_nxt = ST_ADDR;
            ST_ADDR:   if (abort) state_nxt = ST_HUNT; else if (pop) state_nxt = ST_DATA;
            ST_DATA:   if (abort) state_nxt = ST_HUNT; else if (pop) state_nxt = ST_CSUM;
            ST_CSUM:   if (abort) state_nxt = ST_HUNT;
                       else if (pop) state_nxt = csum_ok ? ST_EXEC : ST_RESP;
            ST_EXEC:   state_nxt = (cmd_q == CMD_LUT_RD) ? ST_RDWAIT : ST_RESP;
            ST_RDWAIT: state_nxt = ST_RESP;
            ST_RESP:   if (!txFull) state_nxt = ST_HUNT;
            default:   state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        rxRead  = pop;
        lutWe   = !rst && (state == ST_EXEC) && (cmd_q == CMD_LUT_WR);
        lutRe   = !rst && (state == ST_EXEC) && (cmd_q == CMD_LUT_RD);
        txWrite = !rst && (state == ST_RESP) && !txFull;
    end

    assign lutAddr  = addr_q[LUTADDRBIT-1:0];
    assign lutWdata = data_q[LUTDATABIT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            txData      <= '0;
            gammaEnable <= 1'b0;
            errCount    <= '0;
        end else begin
            if (pop && !abort) begin
                case (state)
                    ST_CMD:  cmd_q  <= rxData;
                    ST_ADDR: addr_q <= rxData;
                    ST_DATA: data_q <= rxData;
                    ST_CSUM: if (!csum_ok) txData <= RESP_NAK;
                    default: ;
                endcase
            end
            if (state == ST_EXEC) begin
                if (cmd_q == CMD_CTRL_WR) gammaEnable <= data_q[0];
                txData <= RESP_ACK;
            end
            // Read data replaces the provisional ACK one clock after the strobe.
            if (state == ST_RDWAIT) txData <= 8'(lutRdata);
            if (err_inc && (errCount != 8'hFF)) errCount <= errCount + 8'd1;
        end
    end

endmodule
